// File: rtl/count_ctrl_pkg.sv
// ============================================================================
// Module      : count_ctrl_pkg
// Description : Shared state encoding, speed codes and reload helper for the
//               count-rate sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package count_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } ctrl_state_t;

    localparam logic [1:0] c_SPEED_EVERY      = 2'b00;
    localparam logic [1:0] c_SPEED_1HZ        = 2'b01;
    localparam logic [1:0] c_SPEED_HALF_HZ    = 2'b10;
    localparam logic [1:0] c_SPEED_QUARTER_HZ = 2'b11;

    // Divider reload value; the tick period is this value plus one cycle.
    function automatic int unsigned reload_value(input logic [1:0] speed,
                                                 input int unsigned clk_hz);
        int unsigned r;
        case (speed)
            c_SPEED_EVERY:   r = 0;
            c_SPEED_1HZ:     r = clk_hz - 1;
            c_SPEED_HALF_HZ: r = 2 * clk_hz - 1;
            default:         r = 4 * clk_hz - 1;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/count_rate_ctrl_rate_divider.sv
// ============================================================================
// Module      : rate_divider
// Description : Saturating down-counter with load and hold; flags zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rate_divider #(
    parameter int DIV_W = 28
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             hold,
    input  logic [DIV_W-1:0] load_val,
    output logic             zero
);

    logic [DIV_W-1:0] r_count;

    // Load wins over hold; counting stops at zero until the next load.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (!hold && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/count_rate_ctrl.sv
// ============================================================================
// Module      : count_rate_ctrl
// Description : Run/pause/step sequencer issuing clear and count-enable pulses
//               to the event counter. Build option COUNT_RATE_WRAP_EN makes
//               the count wrap at the limit instead of stopping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_rate_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int DIV_W  = 28,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic [1:0]       speed,
    input  logic [CNT_W-1:0] limit,
    input  logic [CNT_W-1:0] cnt_val,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    ctrl_state_t      r_state;
    ctrl_state_t      w_state_nxt;
    logic             r_cnt_en;
    logic             r_cnt_clr;
    logic             w_en_nxt;
    logic             w_clr_nxt;
    logic             w_div_load;
    logic             w_div_hold;
    logic             w_div_zero;
    logic             w_tick;
    logic             w_at_limit;
    logic [CNT_W-1:0] w_proj;
    logic [DIV_W-1:0] w_reload;

    // cnt_val lags our pulses by one cycle, so compare against the value the
    // counter will hold once the pulse currently on the wire has landed.
    assign w_proj     = r_cnt_clr ? '0 : (cnt_val + CNT_W'(r_cnt_en));
    assign w_at_limit = (w_proj == limit);
    assign w_tick     = (r_state == ST_RUN) && !stop && w_div_zero && !r_cnt_clr;
    assign w_reload   = DIV_W'(reload_value(speed, CLK_HZ));

    rate_divider #(
        .DIV_W (DIV_W)
    ) u_rate_divider (
        .clk      (clk),
        .reset    (reset),
        .load     (w_div_load),
        .hold     (w_div_hold),
        .load_val (w_reload),
        .zero     (w_div_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_en_nxt    = 1'b0;
        w_clr_nxt   = 1'b0;
        w_div_load  = 1'b0;
        w_div_hold  = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (start && !stop) begin
                    w_state_nxt = ST_RUN;
                    w_clr_nxt   = 1'b1;
                    w_div_load  = 1'b1;
                end
            end
            ST_RUN: begin
                w_div_hold = stop;
                if (stop) begin
                    w_state_nxt = ST_PAUSE;
                end else if (w_tick) begin
                    w_div_load = 1'b1;
                    if (w_at_limit) begin
`ifdef COUNT_RATE_WRAP_EN
                        w_clr_nxt   = 1'b1;
`else
                        w_state_nxt = ST_DONE;
`endif
                    end else begin
                        w_en_nxt = 1'b1;
                    end
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    w_state_nxt = ST_PAUSE;
                end else if (start) begin
                    w_state_nxt = ST_RUN;
                end else if (step) begin
                    if (w_at_limit) begin
`ifdef COUNT_RATE_WRAP_EN
                        w_clr_nxt   = 1'b1;
`else
                        w_state_nxt = ST_DONE;
`endif
                    end else begin
                        w_en_nxt = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (start) begin
                    w_state_nxt = ST_RUN;
                    w_clr_nxt   = 1'b1;
                    w_div_load  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt_en  <= 1'b0;
            r_cnt_clr <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt_en  <= w_en_nxt;
            r_cnt_clr <= w_clr_nxt;
        end
    end

    assign cnt_en  = r_cnt_en;
    assign cnt_clr = r_cnt_clr;
    assign busy    = (r_state == ST_RUN);
    assign done    = (r_state == ST_DONE);
    assign state   = r_state;

endmodule

`default_nettype wire

// File: doc/count_rate_ctrl.md
Name: count_rate_ctrl

Overview:
Sequencer for the 8-bit event counter and its hex display path. It generates synchronous clear and count-enable pulses for the counter at a switch-selected rate, supports run/pause/single-step, and stops when the observed count reaches a programmable limit. It sits between board switches/keys and the counter.

Parameters:
CLK_HZ, 50000000, clock frequency; sets the 1 Hz reload value (benches use a small value, e.g. 4).
DIV_W, 28, rate-divider width; must hold 4*CLK_HZ-1.
CNT_W, 8, width of cnt_val and limit.

Ports:
clk  in  1  system clock, all logic on rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  one-cycle command: start, or resume from pause.
stop  in  1  one-cycle command: pause, or return to idle from done.
step  in  1  one-cycle command: single count while paused.
speed  in  2  rate select: 00 every cycle, 01 1 Hz, 10 0.5 Hz, 11 0.25 Hz.
limit  in  CNT_W  terminal count.
cnt_val  in  CNT_W  current counter value, fed back from the counter.
cnt_en  out  1  registered one-cycle count-enable pulse to the counter.
cnt_clr  out  1  registered one-cycle synchronous clear pulse to the counter.
busy  out  1  high in RUN.
done  out  1  high in DONE.
state  out  2  encoded FSM state, for debug LEDs.

Behaviour:
- Reset:
  - state = IDLE; divider = 0.
  - cnt_en, cnt_clr, busy and done are all 0 on the cycle after reset is sampled.
  - Reset mid-operation has the same effect; no pending pulse survives it.
- Reload value R, sampled at each load/reload:
  - speed 00: R = 0.
  - speed 01: R = CLK_HZ-1.
  - speed 10: R = 2*CLK_HZ-1.
  - speed 11: R = 4*CLK_HZ-1.
  - A speed change takes effect at the next reload only.
- IDLE:
  - start → RUN.
  - On the first RUN cycle, cnt_clr = 1 and the divider is loaded with R.
  - stop and step are ignored.
- RUN, divider behaviour:
  - The divider decrements every cycle.
  - When it is 0, a "tick" occurs and the divider reloads with R.
  - Cycles with cnt_clr = 1 never produce a tick, because cnt_val is stale during them.
- RUN, on a tick:
  - If cnt_val == limit: → DONE, and no cnt_en is issued.
  - Otherwise: cnt_en = 1 on the next cycle.
  - The cnt_en period is therefore R+1 cycles; speed 00 gives one pulse per cycle.
- RUN, commands:
  - stop → PAUSE; the divider value is frozen.
  - start is ignored.
- PAUSE:
  - start → RUN, resuming with the frozen divider value and no clear.
  - step: if cnt_val != limit, one cnt_en pulse on the next cycle; otherwise → DONE.
  - Back-to-back steps are each honoured.
- DONE:
  - done = 1.
  - start → RUN with a cnt_clr pulse and divider load, exactly as from IDLE.
  - stop → IDLE.
- Simultaneous commands:
  - stop has priority over start, then start over step.
  - Exception: in PAUSE, start+step acts as start only.
- Boundaries:
  - limit = 0: start produces a clear, then → DONE with zero cnt_en pulses.
  - limit = 2^CNT_W-1: reaches DONE at full scale; the counter never wraps.
  - cnt_en and cnt_clr are never high in the same cycle.
- State encoding: IDLE = 0, RUN = 1, PAUSE = 2, DONE = 3.

Optional Feature:
COUNT_RATE_WRAP_EN
- Defined: on a tick with cnt_val == limit, or a paused step at the limit, the block issues a cnt_clr pulse instead of entering DONE, and stays in the current state. The count wraps to 0 continuously; DONE is unreachable.
- Undefined: behaviour exactly as above.

Decomposition:
- Package count_ctrl_pkg holds:
  - the state enum (IDLE/RUN/PAUSE/DONE) and its encoding;
  - the speed code constants;
  - a reload-value function of (speed, CLK_HZ).
- One sub-module, rate_divider:
  - DIV_W down-counter with load, hold and reload inputs;
  - emits a zero-flag.
- The FSM and output registers live in count_rate_ctrl.

Test Plan:
Benches use CLK_HZ = 4 and a behavioural counter model driving cnt_val.
1. Reset: assert reset 2 cycles with start=1 → state=0 and cnt_en, cnt_clr, busy, done all 0; start is ignored during reset.
2. speed=00, limit=3, start pulse → cnt_clr on the first RUN cycle, then cnt_en on 3 consecutive cycles, then done=1 and state=3. Exactly 3 enables, no 4th.
3. speed=01, limit=10 → cnt_en exactly every 4 cycles. Switch to speed=11 mid-run → after the next reload, period is 16 cycles.
4. speed=01, stop in RUN, then step ×2 → state=2, exactly 2 cnt_en pulses, and the divider value is unchanged. Start → the first tick arrives after the remaining frozen count, with no cnt_clr.
5. start and stop in the same cycle during RUN → PAUSE. limit=0 start → DONE with 0 enables. Reset mid-RUN → IDLE next cycle with cnt_en=0.
6. With COUNT_RATE_WRAP_EN, speed=00, limit=2 → repeating sequence en, en, clr; done is never asserted.
